// File: rtl/complex_div_if.sv
`default_nettype none
// ============================================================================
// Module      : complex_div_if
// Description : Operand and result handshake bundle for complex_div.
// Revision    : 1.0
// ============================================================================
interface complex_div_if #(
    parameter int P_INPUT_WIDTH    = 8,
    parameter int P_POINT_POSITION = 3
);
    localparam int c_OW = P_INPUT_WIDTH + P_POINT_POSITION + 1;

    logic                     i_valid;
    logic                     o_ready;
    logic [P_INPUT_WIDTH-1:0] i_Ar;
    logic [P_INPUT_WIDTH-1:0] i_Ai;
    logic [P_INPUT_WIDTH-1:0] i_Br;
    logic [P_INPUT_WIDTH-1:0] i_Bi;
    logic                     o_valid;
    logic                     i_ready;
    logic [c_OW-1:0]          o_ResR;
    logic [c_OW-1:0]          o_ResI;
    logic                     o_dz;

    modport master (
        output i_valid, i_Ar, i_Ai, i_Br, i_Bi, i_ready,
        input  o_ready, o_valid, o_ResR, o_ResI, o_dz
    );

    modport slave (
        input  i_valid, i_Ar, i_Ai, i_Br, i_Bi, i_ready,
        output o_ready, o_valid, o_ResR, o_ResI, o_dz
    );
endinterface
`default_nettype wire

// File: rtl/complex_div.sv
`default_nettype none
// ============================================================================
// Module      : complex_div
// Description : Iterative fixed-point complex divider Q = A / B, one quotient
//               bit per cycle on both components, truncating toward zero.
// Revision    : 1.0
// ============================================================================
module complex_div #(
    parameter int P_INPUT_WIDTH    = 8,
    parameter int P_POINT_POSITION = 3
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst,
    complex_div_if.slave bus
);
    localparam int c_W  = P_INPUT_WIDTH;
    localparam int c_F  = P_POINT_POSITION;
    localparam int c_K  = c_W + c_F;
    localparam int c_OW = c_K + 1;
    localparam int c_PW = 2 * c_W;
    localparam int c_NW = 2 * c_W + 1;
    localparam int c_XW = c_NW + c_F;
    localparam int c_CW = $clog2(c_K);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_K - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [c_CW-1:0]         r_cnt;
    logic signed [c_W-1:0]   r_Ar, r_Ai, r_Br, r_Bi;
    logic [c_NW-1:0]         r_D;
    logic                    r_dz;
    logic                    r_dzOut;
    logic [c_NW-1:0]         r_rem [2];
    logic [c_K-1:0]          r_quo [2];
    logic [1:0]              r_neg;
    logic [c_OW-1:0]         r_res [2];

    logic signed [c_PW-1:0]  w_pArBr, w_pAiBi, w_pAiBr, w_pArBi, w_pBrBr, w_pBiBi;
    logic [c_NW-1:0]         w_D;
    logic signed [c_NW-1:0]  w_N [2];
    logic [c_XW-1:0]         w_x [2];
    logic [c_NW:0]           w_trial [2];
    logic [c_NW-1:0]         w_diff [2];
    logic                    w_ge [2];

    assign w_pArBr = c_PW'(r_Ar) * c_PW'(r_Br);
    assign w_pAiBi = c_PW'(r_Ai) * c_PW'(r_Bi);
    assign w_pAiBr = c_PW'(r_Ai) * c_PW'(r_Br);
    assign w_pArBi = c_PW'(r_Ar) * c_PW'(r_Bi);
    assign w_pBrBr = c_PW'(r_Br) * c_PW'(r_Br);
    assign w_pBiBi = c_PW'(r_Bi) * c_PW'(r_Bi);
    assign w_D     = c_NW'($unsigned(w_pBrBr)) + c_NW'($unsigned(w_pBiBi));

    // Lane 0 is the real component, lane 1 the imaginary one.
    always_comb begin
        w_N[0] = c_NW'(w_pArBr) + c_NW'(w_pAiBi);
        w_N[1] = c_NW'(w_pAiBr) - c_NW'(w_pArBi);
        for (int i = 0; i < 2; i++) begin
            w_x[i]     = {(w_N[i][c_NW-1] ? $unsigned(-w_N[i]) : $unsigned(w_N[i])), {c_F{1'b0}}};
            w_trial[i] = {r_rem[i], r_quo[i][c_K-1]};
            w_ge[i]    = (w_trial[i] >= {1'b0, r_D});
            w_diff[i]  = w_trial[i][c_NW-1:0] - r_D;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_stateNext;
    end

    // A zero divisor implies zero numerators, so it rides through SIGN
    // with all-zero quotients and lands in DONE two edges after acceptance.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (bus.i_valid) w_stateNext = S_LOAD;
            S_LOAD: w_stateNext = (w_D == '0) ? S_SIGN : S_DIV;
            S_DIV:  if (r_cnt == c_LAST) w_stateNext = S_SIGN;
            S_SIGN: w_stateNext = S_DONE;
            S_DONE: if (bus.i_ready) w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_Ar    <= '0;
            r_Ai    <= '0;
            r_Br    <= '0;
            r_Bi    <= '0;
            r_D     <= '0;
            r_dz    <= 1'b0;
            r_dzOut <= 1'b0;
            r_neg   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rem[i] <= '0;
                r_quo[i] <= '0;
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_Ar <= bus.i_Ar;
                        r_Ai <= bus.i_Ai;
                        r_Br <= bus.i_Br;
                        r_Bi <= bus.i_Bi;
                    end
                end
                S_LOAD: begin
                    r_D   <= w_D;
                    r_dz  <= (w_D == '0);
                    r_cnt <= '0;
                    // Upper dividend bits seed the remainder; they are below D
                    // because the quotient always fits in K bits.
                    for (int i = 0; i < 2; i++) begin
                        r_neg[i] <= w_N[i][c_NW-1];
                        r_rem[i] <= c_NW'(w_x[i][c_XW-1:c_K]);
                        r_quo[i] <= w_x[i][c_K-1:0];
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    for (int i = 0; i < 2; i++) begin
                        r_rem[i] <= w_ge[i] ? w_diff[i] : w_trial[i][c_NW-1:0];
                        r_quo[i] <= {r_quo[i][c_K-2:0], w_ge[i]};
                    end
                end
                S_SIGN: begin
                    r_dzOut <= r_dz;
                    for (int i = 0; i < 2; i++) begin
                        r_res[i] <= r_neg[i] ? -c_OW'(r_quo[i]) : c_OW'(r_quo[i]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = (r_state == S_IDLE);
    assign bus.o_valid = (r_state == S_DONE);
    assign bus.o_ResR  = r_res[0];
    assign bus.o_ResI  = r_res[1];
    assign bus.o_dz    = r_dzOut;
endmodule
`default_nettype wire
